// File: rtl/sd_interpolation_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sd_interpolation_if                                           |
// | Brief    : Sample handshake and modulator outputs of sd_interpolation.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface sd_interpolation_if #(
    parameter int IN_W = 24
);
    logic signed [IN_W-1:0] sample_in;
    logic                   sample_valid;
    logic                   sample_ready;
    logic                   bit_out;
    logic signed [IN_W-1:0] interp_out;
    logic                   underrun;
    logic                   running;

    modport master (
        output sample_in, sample_valid,
        input  sample_ready, bit_out, interp_out, underrun, running
    );

    modport slave (
        input  sample_in, sample_valid,
        output sample_ready, bit_out, interp_out, underrun, running
    );
endinterface
`default_nettype wire

// File: rtl/sd_interpolation.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sd_interpolation                                              |
// | Brief    : Linear x2**LOG2_N interpolator feeding a 1st-order SD DAC.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sd_interpolation #(
    parameter int IN_W   = 24,
    parameter int LOG2_N = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    sd_interpolation_if.slave bus
);
    localparam int c_IW = IN_W + 2;
    localparam int c_SW = IN_W + 1;
    localparam int c_AW = IN_W + 3;
    localparam int c_MW = IN_W + 4;

    localparam logic [LOG2_N-1:0]      c_PH_LAST = {LOG2_N{1'b1}};
    localparam logic signed [c_IW-1:0] c_OUT_MAX = {3'b000, {(IN_W-1){1'b1}}};
    localparam logic signed [c_IW-1:0] c_OUT_MIN = {3'b111, {(IN_W-1){1'b0}}};
    localparam logic signed [c_MW-1:0] c_FS      = {4'b0000, 1'b1, {(IN_W-1){1'b0}}};
    localparam logic signed [c_MW-1:0] c_INT_MAX = {2'b00, {(c_AW-1){1'b1}}};
    localparam logic signed [c_MW-1:0] c_INT_MIN = {2'b11, {(c_AW-1){1'b0}}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_boundary;
    logic                     w_load;

    logic signed [IN_W-1:0]   r_buf;
    logic                     r_buf_full;
    logic signed [IN_W-1:0]   r_cur;
    logic signed [c_SW-1:0]   r_step;
    logic signed [c_IW-1:0]   r_interp;
    logic [LOG2_N-1:0]        r_ph;
    logic                     r_underrun;
    logic signed [c_AW-1:0]   r_int;
    logic                     r_bit;

    logic signed [c_SW-1:0]   w_diff;
    logic signed [c_SW-1:0]   w_step_new;
    logic signed [c_IW-1:0]   w_interp_inc;
    logic signed [IN_W-1:0]   w_out;
    logic signed [c_MW-1:0]   w_fb;
    logic signed [c_MW-1:0]   w_int_sum;
    logic signed [c_AW-1:0]   w_int_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The first consume out of IDLE counts as a segment boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_boundary  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_buf_full) begin
                    w_state_nxt = S_RUN;
                    w_boundary  = 1'b1;
                end
            end
            S_RUN: begin
                w_boundary = (r_ph == c_PH_LAST);
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_load       = bus.sample_valid && !r_buf_full;
    assign w_diff       = {r_buf[IN_W-1], r_buf} - {r_cur[IN_W-1], r_cur};
    assign w_step_new   = w_diff >>> LOG2_N;
    assign w_interp_inc = r_interp + {{(c_IW-c_SW){r_step[c_SW-1]}}, r_step};

    // Floored step can overshoot the target slightly, so clamp to IN_W.
    always_comb begin
        w_out = r_interp[IN_W-1:0];
        if (r_interp > c_OUT_MAX) begin
            w_out = {1'b0, {(IN_W-1){1'b1}}};
        end else if (r_interp < c_OUT_MIN) begin
            w_out = {1'b1, {(IN_W-1){1'b0}}};
        end
    end

    assign w_fb      = r_bit ? c_FS : -c_FS;
    assign w_int_sum = {{(c_MW-c_AW){r_int[c_AW-1]}}, r_int}
                     + {{(c_MW-IN_W){w_out[IN_W-1]}}, w_out}
                     - w_fb;

    always_comb begin
        w_int_nxt = w_int_sum[c_AW-1:0];
        if (w_int_sum > c_INT_MAX) begin
            w_int_nxt = {1'b0, {(c_AW-1){1'b1}}};
        end else if (w_int_sum < c_INT_MIN) begin
            w_int_nxt = {1'b1, {(c_AW-1){1'b0}}};
        end
    end

    // Load only happens while empty and consume only while full, so the two
    // updates of r_buf_full below never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_cur      <= '0;
            r_step     <= '0;
            r_interp   <= '0;
            r_ph       <= '0;
            r_underrun <= 1'b0;
            r_int      <= '0;
            r_bit      <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_load) begin
                r_buf      <= bus.sample_in;
                r_buf_full <= 1'b1;
            end

            if (w_boundary) begin
                r_ph     <= '0;
                r_interp <= {{(c_IW-IN_W){r_cur[IN_W-1]}}, r_cur};
                if (r_buf_full) begin
                    r_step     <= w_step_new;
                    r_cur      <= r_buf;
                    r_buf_full <= 1'b0;
                end else begin
                    r_step     <= '0;
                    r_underrun <= 1'b1;
                end
            end else if (r_state == S_RUN) begin
                r_ph     <= r_ph + 1'b1;
                r_interp <= w_interp_inc;
            end

            if (r_state == S_RUN) begin
                r_int <= w_int_nxt;
                r_bit <= ~w_int_nxt[c_AW-1];
            end else begin
                r_int <= '0;
                r_bit <= ~r_bit;
            end
        end
    end

    assign bus.sample_ready = ~r_buf_full;
    assign bus.bit_out      = r_bit;
    assign bus.interp_out   = w_out;
    assign bus.underrun     = r_underrun;
    assign bus.running      = (r_state == S_RUN);

endmodule
`default_nettype wire
